// File: rtl/join_pkg.sv
// Shared types and sizing helpers for the branch join point.
package join_pkg;

    // Join FSM states: WAIT means neither branch captured yet.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        HAVE_A = 3'd2,
        HAVE_B = 3'd3,
        DONE   = 3'd4
    } join_state_t;

    // Default join window length in cycles.
    localparam int TIMEOUT_DEFAULT = 32;

    // Counter width for a given window: one spare bit above $clog2 so the
    // terminal value TIMEOUT-1 always fits with headroom for saturation.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/join_timer.sv
// Clear/enable saturating window counter with terminal-count flag.
module join_timer #(
    parameter int W  = 6,
    parameter int TC = 31
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    // Count window cycles; clear wins over enable, hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TC));

endmodule

// File: rtl/join_collector.sv
// Join point for two independently launched result branches A and B.
// Captures one result per branch, then pulses out_valid; aborts with a
// timeout pulse if the window closes before both branches arrive.
module join_collector
    import join_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ORDERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             timeout,
    output logic             order_err,
    output logic             busy
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    join_state_t state;
    logic        win_open;
    logic        acc_a;
    logic        acc_b;
    logic        got_a;
    logic        got_b;
    logic        tc;

    // Handshake readiness is a pure decode of the state register.
    assign a_ready  = (state == WAIT) || (state == HAVE_B);
    assign b_ready  = (state == HAVE_A) || ((ORDERED == 0) && (state == WAIT));
    assign win_open = (state == WAIT) || (state == HAVE_A) || (state == HAVE_B);

    assign acc_a = a_valid && a_ready;
    assign acc_b = b_valid && b_ready;

    // Branch held either from an earlier cycle or accepted right now.
    assign got_a = (state == HAVE_A) || acc_a;
    assign got_b = (state == HAVE_B) || acc_b;

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    join_timer #(
        .W  (CNT_W),
        .TC (TIMEOUT - 1)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state == IDLE) && start),
        .en    (win_open),
        .tc    (tc)
    );

    // Join FSM with capture registers and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_a     <= '0;
            out_b     <= '0;
            timeout   <= 1'b0;
            order_err <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            order_err <= 1'b0;
            if (acc_a) out_a <= a_data;
            if (acc_b) out_b <= b_data;
            case (state)
                IDLE: begin
                    if (start) state <= WAIT;
                end
                WAIT, HAVE_A, HAVE_B: begin
                    // B showing up before A in ordered mode is flagged, not taken.
                    if ((ORDERED != 0) && (state == WAIT) && b_valid)
                        order_err <= 1'b1;
                    // Completion on the last window cycle beats the timeout.
                    if (got_a && got_b) begin
                        state <= DONE;
                    end else if (tc) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else if (got_a) begin
                        state <= HAVE_A;
                    end else if (got_b) begin
                        state <= HAVE_B;
                    end
                end
                DONE: begin
                    // Start is not honoured here; it must be re-presented in IDLE.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/join_collector.md
Name: join_collector

Overview:
- Synthesizable join point for two independently launched result branches (A and B).
- Captures one result from each branch via valid/ready, then emits a single joined result pulse.
- Supports ORDERED mode, where B is accepted only strictly after A, and bounds the join window with a timeout.
- Sits downstream of a fork/dispatch stage and aggregates the branch completions back into one transaction.

Parameters:
- WIDTH, 4, data width of each branch result.
- TIMEOUT, 32, cycles after start before an incomplete join aborts (legal range 2..65535).
- ORDERED, 1, 1: B accepted only in a cycle after A is captured; 0: any order, same cycle allowed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  opens a join window; honoured only in IDLE.
- a_valid  input  1  branch A result valid.
- a_data  input  WIDTH  branch A result.
- a_ready  output  1  A accepted this cycle when a_valid && a_ready.
- b_valid  input  1  branch B result valid.
- b_data  input  WIDTH  branch B result.
- b_ready  output  1  B accepted this cycle when b_valid && b_ready.
- out_valid  output  1  one-cycle pulse: join complete.
- out_a  output  WIDTH  captured A; held until next capture.
- out_b  output  WIDTH  captured B; held until next capture.
- timeout  output  1  one-cycle pulse: window expired incomplete.
- order_err  output  1  one-cycle pulse: ORDERED mode, B valid before A captured.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0. All outputs 0: out_a, out_b, out_valid, timeout, order_err, busy, a_ready, b_ready.
- States: IDLE, WAIT (neither captured), HAVE_A, HAVE_B, DONE.
- IDLE:
  - a_ready = b_ready = 0.
  - start -> WAIT, counter cleared to 0.
- WAIT:
  - a_ready = 1. b_ready = 0 when ORDERED=1, else 1.
  - A only -> HAVE_A. B only (ORDERED=0) -> HAVE_B. Both accepted in the same cycle (ORDERED=0) -> DONE.
  - ORDERED=1 with b_valid asserted: order_err pulses next cycle; B is not accepted.
  - This rule also covers a_valid && b_valid in the same cycle: A is captured, B is rejected with order_err.
- HAVE_A: a_ready = 0, b_ready = 1. B accepted -> DONE.
- HAVE_B: b_ready = 0, a_ready = 1. A accepted -> DONE.
- Capture: out_a / out_b are registered on the accept edge.
- DONE:
  - out_valid = 1 for exactly one cycle, busy still 1. Next state IDLE.
  - Latency: out_valid rises one cycle after the edge that captured the second branch.
- Counter:
  - Increments every cycle in WAIT, HAVE_A and HAVE_B, and saturates.
  - If counter == TIMEOUT-1 and the join does not complete that cycle: timeout pulses next cycle, state -> IDLE, out_a/out_b keep partial captures.
  - Completion in that same cycle wins over timeout.
- start outside IDLE is ignored; no queuing.
- In DONE, the same-cycle start is ignored. A new start is honoured from the following IDLE cycle.
- a_ready and b_ready are Moore outputs, decoded from state only.
- Reset mid-window aborts immediately; no out_valid or timeout pulse is generated.

Decomposition:
- Shared package join_pkg: state enum (IDLE, WAIT, HAVE_A, HAVE_B, DONE) and a localparam for the counter width, $clog2(TIMEOUT)+1.
- One natural sub-module: join_timer (clear/enable saturating counter with terminal-count flag).
- FSM, capture registers and handshake decode stay in join_collector.

Test Plan:
- Ordered normal, ORDERED=1: start; A=1 at cycle 3; B=2 at cycle 10 -> out_valid at cycle 11 with out_a=1, out_b=2; timeout=0.
- Ordered violation, ORDERED=1: start, B=2 first -> b_ready=0, order_err pulse next cycle. Then A=1, B=2 -> out_valid with out_a=1, out_b=2.
- Simultaneous, ORDERED=0: start; A=5 and B=9 in the same cycle -> out_valid exactly one cycle later, out_a=5, out_b=9.
- Timeout, TIMEOUT=8: start; A=3 only -> timeout pulse 8 cycles after start, busy=0, out_valid never asserted, out_a=3.
- Boundary: B arrives in the cycle where counter==TIMEOUT-1 -> out_valid=1, timeout=0.
- Reset mid-window: assert rst_n=0 in HAVE_A -> all outputs 0 asynchronously. After release, start is honoured and a full join completes.
